// File: rtl/spdif_bmc_rx.sv
// S/PDIF biphase-mark receive front end: pulse-width measurement, S/M/L
// classification, B/M/W preamble detection and 28-slot subframe decode.
module spdif_bmc_rx #(
   parameter int SHORT_MAX  = 9,
   parameter int MEDIUM_MAX = 15,
   parameter int LONG_MAX   = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spdif,
   output logic [27:0] subframe_data,
   output logic [1:0]  preamble,
   output logic        parity_ok,
   output logic        subframe_valid,
   output logic        fault,
   output logic        locked
);

   typedef enum logic [1:0] {ST_HUNT, ST_PRE, ST_DATA, ST_SYNC} state_t;
   typedef enum logic [1:0] {PW_S, PW_M, PW_L, PW_X} pw_t;

   localparam logic [4:0] W_SHORT  = 5'(SHORT_MAX);
   localparam logic [4:0] W_MEDIUM = 5'(MEDIUM_MAX);
   localparam logic [4:0] W_LONG   = 5'(LONG_MAX);
   localparam logic [4:0] W_TMO    = 5'(LONG_MAX + 1);
   localparam logic [4:0] W_SAT    = 5'd31;

   // input register, width counter and the edge/width pipeline stage
   logic        spdif_q;
   logic [4:0]  cnt_q, cnt_d;
   logic        edge_q, edge_d;
   logic [4:0]  width_q, width_d;
   pw_t         pw;

   // decoder state
   state_t      state_q, state_d;
   logic [1:0]  pidx_q, pidx_d;
   pw_t         p2_q, p2_d, p3_q, p3_d;
   logic        half_q, half_d;
   logic [4:0]  slot_q, slot_d;
   logic [27:0] shift_q, shift_d;
   logic [1:0]  pre_q, pre_d;
   logic        take_bit;
   logic        bit_val;

   // registered outputs
   logic [27:0] data_q, data_d;
   logic [1:0]  preamble_q, preamble_d;
   logic        parity_q, parity_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        locked_q, locked_d;

   // Edge detect against the registered line; the width of the pulse that just
   // closed is captured so classification happens one cycle after the edge.
   always_comb begin
      edge_d  = spdif ^ spdif_q;
      width_d = width_q;
      cnt_d   = cnt_q;
      if (edge_d) begin
         width_d = cnt_q;
         cnt_d   = 5'd1;
      end else if (cnt_q != W_SAT) begin
         cnt_d = cnt_q + 5'd1;
      end
   end

   // Classify the captured pulse width into 1, 2 or 3 UI (or out of range).
   always_comb begin
      if (width_q <= W_SHORT)       pw = PW_S;
      else if (width_q <= W_MEDIUM) pw = PW_M;
      else if (width_q <= W_LONG)   pw = PW_L;
      else                          pw = PW_X;
   end

   // Decoder FSM next state: preamble matching, bit assembly, subframe close.
   always_comb begin
      state_d    = state_q;
      pidx_d     = pidx_q;
      p2_d       = p2_q;
      p3_d       = p3_q;
      half_d     = half_q;
      slot_d     = slot_q;
      shift_d    = shift_q;
      pre_d      = pre_q;
      data_d     = data_q;
      preamble_d = preamble_q;
      parity_d   = parity_q;
      valid_d    = 1'b0;
      fault_d    = 1'b0;
      take_bit   = 1'b0;
      bit_val    = 1'b0;
      if (state_q != ST_HUNT && cnt_q == W_TMO) begin
         // line stopped toggling: drop the partial subframe once
         fault_d = 1'b1;
         state_d = ST_HUNT;
         half_d  = 1'b0;
      end else if (edge_q) begin
         case (state_q)
            ST_HUNT: begin
               if (pw == PW_L) begin
                  state_d = ST_PRE;
                  pidx_d  = 2'd1;
               end
            end
            ST_PRE: begin
               if (pidx_q == 2'd1) begin
                  p2_d   = pw;
                  pidx_d = 2'd2;
               end else if (pidx_q == 2'd2) begin
                  p3_d   = pw;
                  pidx_d = 2'd3;
               end else begin
                  state_d = ST_DATA;
                  slot_d  = 5'd0;
                  half_d  = 1'b0;
                  if (p2_q == PW_S && p3_q == PW_S && pw == PW_L)      pre_d = 2'd0;
                  else if (p2_q == PW_L && p3_q == PW_S && pw == PW_S) pre_d = 2'd1;
                  else if (p2_q == PW_M && p3_q == PW_S && pw == PW_M) pre_d = 2'd2;
                  else begin
                     fault_d = 1'b1;
                     state_d = ST_HUNT;
                  end
               end
            end
            ST_DATA: begin
               if (pw == PW_M && !half_q) begin
                  take_bit = 1'b1;
               end else if (pw == PW_S && !half_q) begin
                  half_d = 1'b1;
               end else if (pw == PW_S && half_q) begin
                  take_bit = 1'b1;
                  bit_val  = 1'b1;
                  half_d   = 1'b0;
               end else begin
                  fault_d = 1'b1;
                  state_d = ST_HUNT;
                  half_d  = 1'b0;
               end
               if (take_bit) begin
                  // LSB-first on the wire: newest bit enters at the top
                  shift_d = {bit_val, shift_q[27:1]};
                  slot_d  = slot_q + 5'd1;
                  if (slot_q == 5'd27) state_d = ST_SYNC;
               end
            end
            default: begin
               if (pw == PW_L) begin
                  // closing L doubles as the first pulse of the next preamble
                  data_d     = shift_q;
                  preamble_d = pre_q;
                  parity_d   = ~^shift_q;
                  valid_d    = 1'b1;
                  state_d    = ST_PRE;
                  pidx_d     = 2'd1;
               end else begin
                  fault_d = 1'b1;
                  state_d = ST_HUNT;
               end
            end
         endcase
      end
      locked_d = valid_d ? 1'b1 : (fault_d ? 1'b0 : locked_q);
   end

   // All state and outputs registered; reset returns straight to HUNT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spdif_q    <= 1'b0;
         cnt_q      <= 5'd0;
         edge_q     <= 1'b0;
         width_q    <= 5'd0;
         state_q    <= ST_HUNT;
         pidx_q     <= 2'd0;
         p2_q       <= PW_S;
         p3_q       <= PW_S;
         half_q     <= 1'b0;
         slot_q     <= 5'd0;
         shift_q    <= 28'd0;
         pre_q      <= 2'd0;
         data_q     <= 28'd0;
         preamble_q <= 2'd0;
         parity_q   <= 1'b0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         spdif_q    <= spdif;
         cnt_q      <= cnt_d;
         edge_q     <= edge_d;
         width_q    <= width_d;
         state_q    <= state_d;
         pidx_q     <= pidx_d;
         p2_q       <= p2_d;
         p3_q       <= p3_d;
         half_q     <= half_d;
         slot_q     <= slot_d;
         shift_q    <= shift_d;
         pre_q      <= pre_d;
         data_q     <= data_d;
         preamble_q <= preamble_d;
         parity_q   <= parity_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         locked_q   <= locked_d;
      end
   end

   assign subframe_data  = data_q;
   assign preamble       = preamble_q;
   assign parity_ok      = parity_q;
   assign subframe_valid = valid_q;
   assign fault          = fault_q;
   assign locked         = locked_q;

endmodule
